// File: rtl/blast_pkg.sv
// Shared types and constants for the seed-expansion result path.
package blast_pkg;
    localparam int TH        = 200;
    localparam int SEED_BITS = 22;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 16;

    // "end" is a keyword, hence the _addr field names.
    typedef struct packed {
        logic [ADDR_W-1:0] start_addr;
        logic [ADDR_W-1:0] end_addr;
        logic [LEN_W-1:0]  len;
    } hsp_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } state_t;
endpackage

// File: rtl/hsp_fifo.sv
// First-word fall-through FIFO: head data is valid whenever the FIFO is not empty.
// A write into a full FIFO is ignored unless a read happens on the same edge.
module hsp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = $bits(blast_pkg::hsp_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/hsp_collector.sv
// Captures extended hits on each stop edge, filters short ones, merges overlapping or
// adjacent hits into HSP records and queues them for the result writer.
module hsp_collector #(
    parameter int ADDR_W  = 32,
    parameter int MIN_LEN = 22,
    parameter int DEPTH   = 16,
    parameter int LEN_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stop,
    input  logic [ADDR_W-1:0]        locationStart,
    input  logic [ADDR_W-1:0]        locationEnd,
    input  logic                     flush,
    output logic                     hit_valid,
    input  logic                     hit_ready,
    output logic [ADDR_W-1:0]        hit_start,
    output logic [ADDR_W-1:0]        hit_end,
    output logic [LEN_W-1:0]         hit_len,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic                     busy
);
    import blast_pkg::*;

    localparam int REC_W = 2*ADDR_W + LEN_W;

    state_t            state, nstate;
    logic              stop_d;
    logic [ADDR_W-1:0] pstart, pend;
    logic              pvalid;
    logic              ev, malformed, accept, merge;
    logic [ADDR_W-1:0] new_len, span;
    logic [LEN_W-1:0]  rec_len;
    logic              push, load, do_merge, pop, full, empty, drop_ovf;
    logic [REC_W-1:0]  head;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;

    assign ev        = stop & ~stop_d;
    assign malformed = locationEnd < locationStart;
    assign new_len   = locationEnd - locationStart + ADDR_W'(1);
    assign accept    = ev & ~malformed & (new_len >= ADDR_W'(MIN_LEN));
    // Extra bit keeps pend+1 from wrapping at the top of the address space.
    assign merge     = {1'b0, locationStart} <= ({1'b0, pend} + (ADDR_W+1)'(1));

    assign span    = pend - pstart + ADDR_W'(1);
    assign rec_len = (|span[ADDR_W-1:LEN_W]) ? '1 : span[LEN_W-1:0];

    always_comb begin
        nstate   = state;
        push     = 1'b0;
        load     = 1'b0;
        do_merge = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load   = 1'b1;
                    nstate = flush ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (merge) begin
                        do_merge = 1'b1;
                    end else begin
                        push = 1'b1;
                        load = 1'b1;
                    end
                    nstate = flush ? FLUSH : HOLD;
                end else if (flush) begin
                    push   = 1'b1;
                    nstate = IDLE;
                end
            end
            FLUSH: begin
                // Pending is emptied by this push, so a new hit always reloads it.
                push = 1'b1;
                if (accept) begin
                    load   = 1'b1;
                    nstate = flush ? FLUSH : HOLD;
                end else begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    assign pop      = hit_valid & hit_ready;
    assign drop_ovf = push & full & ~pop;
    assign drop_inc = {1'b0, drop_ovf} + {1'b0, ev & malformed};
    assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stop_d     <= 1'b0;
            pstart     <= '0;
            pend       <= '0;
            pvalid     <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state  <= nstate;
            stop_d <= stop;
            if (load) begin
                pstart <= locationStart;
                pend   <= locationEnd;
                pvalid <= 1'b1;
            end else if (do_merge) begin
                if (locationStart < pstart) pstart <= locationStart;
                if (locationEnd > pend)     pend   <= locationEnd;
            end else if (push) begin
                pvalid <= 1'b0;
            end
            if (drop_ovf) overflow <= 1'b1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    hsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({pstart, pend, rec_len}),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .count   (fifo_count)
    );

    assign hit_valid = ~empty;
    assign hit_start = hit_valid ? head[REC_W-1 -: ADDR_W]       : '0;
    assign hit_end   = hit_valid ? head[LEN_W +: ADDR_W]         : '0;
    assign hit_len   = hit_valid ? head[LEN_W-1:0]               : '0;
    assign busy      = pvalid | (state == FLUSH);
endmodule

// File: tb/tb_hsp_collector.sv
// Directed bench for hsp_collector (DEPTH=4) with a scoreboard of expected records.
module tb_hsp_collector;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int D  = 4;

    logic          clk;
    logic          rst;
    logic          stop;
    logic [AW-1:0] locationStart;
    logic [AW-1:0] locationEnd;
    logic          flush;
    logic          hit_valid;
    logic          hit_ready;
    logic [AW-1:0] hit_start;
    logic [AW-1:0] hit_end;
    logic [LW-1:0] hit_len;
    logic [$clog2(D):0] fifo_count;
    logic          overflow;
    logic [15:0]   drop_count;
    logic          busy;

    hsp_collector #(
        .ADDR_W  (AW),
        .MIN_LEN (22),
        .DEPTH   (D),
        .LEN_W   (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stop          (stop),
        .locationStart (locationStart),
        .locationEnd   (locationEnd),
        .flush         (flush),
        .hit_valid     (hit_valid),
        .hit_ready     (hit_ready),
        .hit_start     (hit_start),
        .hit_end       (hit_end),
        .hit_len       (hit_len),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] l;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic expect_rec(input int s, input int e, input int l);
        rec_t r;
        r.s = 32'(s);
        r.e = 32'(e);
        r.l = 32'(l);
        exp_q.push_back(r);
    endtask

    // Compare the head against the scoreboard whenever it will be popped on the coming edge.
    task automatic tick();
        rec_t r;
        @(negedge clk);
        if (hit_valid && hit_ready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_rec: observed start %0d expected no record", hit_start);
            end
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("rec_start", hit_start, r.s);
                chk("rec_end", hit_end, r.e);
                chk("rec_len", 32'(hit_len), r.l);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input int s, input int e);
        locationStart = 32'(s);
        locationEnd   = 32'(e);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        stop = 1'b0;
        flush = 1'b0;
        hit_ready = 1'b0;
        locationStart = '0;
        locationEnd = '0;
        tick();
        tick();
        chk("rst_valid", 32'(hit_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", hit_start, 32'd0);
        rst = 1'b0;
        tick();

        // Single hit then flush.
        hit_ready = 1'b1;
        hit(1000, 1021);
        chk("single_busy_hold", 32'(busy), 32'd1);
        expect_rec(1000, 1021, 22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("single_busy_fall", 32'(busy), 32'd0);
        tick();
        chk("single_count", 32'(fifo_count), 32'd0);
        chk("single_drop", 32'(drop_count), 32'd0);

        // Short hit is silent; malformed hit counts as a drop.
        hit(1000, 1020);
        chk("short_busy", 32'(busy), 32'd0);
        do_flush();
        chk("short_count", 32'(fifo_count), 32'd0);
        chk("short_drop", 32'(drop_count), 32'd0);
        hit(50, 10);
        chk("malformed_drop", 32'(drop_count), 32'd1);
        chk("malformed_busy", 32'(busy), 32'd0);

        // Overlap and adjacency merges.
        hit(1000, 1050);
        hit(1040, 1100);
        expect_rec(1000, 1100, 101);
        do_flush();
        tick();
        hit(2000, 2021);
        hit(2022, 2043);
        expect_rec(2000, 2043, 44);
        do_flush();
        tick();
        chk("merge_count", 32'(fifo_count), 32'd0);

        // Disjoint latency, then ev and flush together.
        hit(1000, 1021);
        expect_rec(1000, 1021, 22);
        expect_rec(5000, 5021, 22);
        expect_rec(9000, 9021, 22);
        locationStart = 32'd5000;
        locationEnd   = 32'd5021;
        stop = 1'b1;
        tick();
        chk("lat_valid", 32'(hit_valid), 32'd1);
        chk("lat_start", hit_start, 32'd1000);
        stop = 1'b0;
        tick();
        locationStart = 32'd9000;
        locationEnd   = 32'd9021;
        stop = 1'b1;
        flush = 1'b1;
        tick();
        chk("evfl_busy", 32'(busy), 32'd1);
        stop = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        tick();
        chk("evfl_busy_end", 32'(busy), 32'd0);
        chk("evfl_count", 32'(fifo_count), 32'd0);

        // Overflow with a stalled consumer.
        hit_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            hit(10000 + k*100, 10021 + k*100);
            if (k < 4) expect_rec(10000 + k*100, 10021 + k*100, 22);
        end
        do_flush();
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_count), 32'd3);
        chk("ovf_head", hit_start, 32'd10000);
        tick();
        chk("ovf_head_stable", hit_start, 32'd10000);
        hit_ready = 1'b1;
        repeat (5) tick();
        chk("drain_count", 32'(fifo_count), 32'd0);

        // Held stop gives one event: the later location must never be captured.
        hit_ready = 1'b0;
        locationStart = 32'd20000;
        locationEnd   = 32'd20021;
        stop = 1'b1;
        tick();
        locationStart = 32'd30000;
        locationEnd   = 32'd30021;
        repeat (4) tick();
        stop = 1'b0;
        tick();
        chk("held_count", 32'(fifo_count), 32'd0);
        chk("held_busy", 32'(busy), 32'd1);
        hit(40000, 40021);
        hit(50000, 50021);
        hit(60000, 60021);
        chk("held_fill", 32'(fifo_count), 32'd3);
        chk("held_head", hit_start, 32'd20000);

        // Asynchronous reset mid-operation.
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(hit_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop", 32'(drop_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(hit_valid), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hsp_collector.md
Name: hsp_collector

Overview:
- Downstream consumer of the seed-expansion FSM.
- On each expansion-done pulse (stop), it captures the final extended hit [locationStart, locationEnd] in DB bit addresses (2 bits per nucleotide).
- It rejects hits shorter than a minimum length and merges overlapping or adjacent hits into one high-scoring-pair (HSP) record.
- Records are buffered in a FIFO and drained through a valid/ready interface to the result writer.

Parameters:
- ADDR_W, 32, width of DB bit addresses.
- MIN_LEN, 22, minimum hit length in bits (end-start+1) to accept; 22 = one 11-nt seed.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- LEN_W, 16, width of reported length.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stop  in  1  expansion-done pulse from the expand stage; location inputs are final in the cycle stop is high.
- locationStart  in  ADDR_W  first bit address of the extended hit.
- locationEnd  in  ADDR_W  last bit address of the extended hit.
- flush  in  1  end-of-database pulse; forces the pending record into the FIFO.
- hit_valid  out  1  FIFO head is valid.
- hit_ready  in  1  consumer accepts the head.
- hit_start  out  ADDR_W  head record start.
- hit_end  out  ADDR_W  head record end.
- hit_len  out  LEN_W  head record length in bits, saturated.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky; a push was attempted while the FIFO was full.
- drop_count  out  16  records lost to overflow plus malformed hits; saturates at 0xFFFF.
- busy  out  1  pending record held or flush in progress.

Behaviour:
- Reset (async, active-high): all outputs 0, pending invalid, FIFO empty, state IDLE, stop_d=0. Reset mid-operation discards the pending record and all FIFO contents immediately.
- Hit event: ev = stop & ~stop_d, where stop_d is stop registered. A stop held high produces exactly one event.
- Malformed hit: locationEnd < locationStart. Discard it and increment drop_count.
- Length filter: len = locationEnd - locationStart + 1, computed at ADDR_W. If len < MIN_LEN, discard silently; no counter change.
- Pending register (pstart, pend, pvalid); merge test: new.start <= pend+1, computed at ADDR_W+1 so pend = max address does not wrap.
- On an accepted event in IDLE: load pending; go to HOLD.
- On an accepted event in HOLD, merge case: pstart = min(pstart, new.start), pend = max(pend, new.end). No push.
- On an accepted event in HOLD, disjoint case: push old pending into the FIFO and load the new hit, both on the same edge.
- flush in IDLE: no action.
- flush in HOLD: push pending; go to IDLE.
- Simultaneous ev and flush: process the hit first, then go to FLUSH. FLUSH pushes pending on the next cycle and returns to IDLE. ev during FLUSH is processed the same way after that push.
- Push record: {pstart, pend, min(pend-pstart+1, 2^LEN_W-1)}.
- Push with FIFO full and no pop in the same cycle: record dropped, overflow=1, drop_count+1.
- Push and pop in the same cycle while full: allowed, no drop.
- FIFO: first-word fall-through. A record pushed at edge k is presented with hit_valid=1 in the cycle after edge k.
- Pop occurs when hit_valid & hit_ready. Outputs are stable while hit_valid & ~hit_ready.
- Read and write pointers wrap modulo DEPTH. fifo_count = write count - read count.
- Latency: a disjoint stop event in cycle M makes the previous record visible on hit_valid in cycle M+1, assuming an empty FIFO.
- busy = pvalid | (state==FLUSH).

Decomposition:
- Shared package blast_pkg holds:
  - constants TH=200, SEED_BITS=22, ADDR_W=32;
  - typedef hsp_t {start, end, len};
  - state enum {IDLE, HOLD, FLUSH}.
- One sub-module: hsp_fifo, a synchronous FWFT FIFO with parameters DEPTH and width sizeof(hsp_t), full/empty/count outputs, and the same clk and rst.

Test Plan:
- Single hit (1000,1021), then flush, hit_ready=1 → one record (1000,1021,22); drop_count=0; busy falls after the push.
- MIN_LEN=40, hit (1000,1021), flush → no record; drop_count=0. Hit (50,10) → discarded, drop_count=1.
- Overlap (1000,1050) then (1040,1100), then flush → single record (1000,1100,101). Adjacent (2000,2021),(2022,2043) → (2000,2043,44).
- Disjoint (1000,1021) at cycle M, then (5000,5021) → (1000,1021) valid at M+1. ev and flush in the same cycle → both records emitted, in order.
- DEPTH=4, hit_ready=0, six disjoint hits then flush → fifo_count=4, overflow=1, drop_count=2. Raise hit_ready → first four records drain in order.
- stop held high 5 cycles → exactly one event. Assert rst with FIFO=3 and pending valid → hit_valid=0, fifo_count=0, overflow=0 immediately, before the next clock edge.
